logic_op_exerciser: RTL

- Self-checking stimulus/response engine for the lab's 16-bit combinational logic-operation units (AND/OR/XOR/NOT).
- Drives operand buses A and B into the unit under test and samples its result Y.
- Compares Y against an internally computed expected value and counts mismatches.
- Used on-board as the driving and checking side of each logic unit's A/B/Y interface.

---
 rtl/logic_op_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 38 +++
 rtl/logic_op_exerciser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-operation exerciser: op encodings, FSM states,
// LFSR seeds/taps, corner vectors and the reference function for expected Y.
// Ports: none (package only).
package logic_op_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic [15:0] SEED_A    = 16'hACE1;
  localparam logic [15:0] SEED_B    = 16'h1D2C;
  // Taps 16,14,13,11 as bit positions 15,13,12,10 of the state register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Corner vectors, element [i] is vector index i.
  localparam logic [3:0][15:0] CORNER_A = {16'hFFFF, 16'hAAAA, 16'hFFFF, 16'h0000};
  localparam logic [3:0][15:0] CORNER_B = {16'hFFFF, 16'h5555, 16'h0000, 16'h0000};

  function automatic logic [15:0] expected_y(input logic [1:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Latency: state_o updates one cycle after load_i/step_i; no backpressure.
// Ports: clk, rst (sync, active-high), load_i/seed_i, step_i, state_o.
module lfsr16
  import logic_op_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;
  logic        fb;

  always_comb begin
    fb      = ^(state_q & LFSR_TAPS);
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {state_q[14:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/logic_op_exerciser.sv
// Drives A/B vectors into a 16-bit logic unit, checks Y, counts mismatches.
// Latency: each vector takes SETTLE+1 cycles; done at start+1+count*(SETTLE+1).
// Backpressure: none; start is only accepted in IDLE and ignored while busy or done.
// Ports: clk/rst (sync active-high), start/op_sel/count (run setup),
//        a_out/b_out/y_in (unit under test), busy/done/pass/err_count/fail_idx (status).
module logic_op_exerciser
  import logic_op_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op_sel,
  input  logic [7:0]      count,
  output logic [15:0]     a_out,
  output logic [15:0]     b_out,
  input  logic [15:0]     y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [7:0]      fail_idx
);

  // WAIT lasts SETTLE-1 cycles; unused when SETTLE==1 (DRIVE goes straight to CHECK).
  localparam int WAIT_LAST = (SETTLE > 2) ? SETTLE - 2 : 0;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      idx_q, idx_d, next_idx;
  logic [15:0]     wait_q, wait_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d, err_inc;
  logic [7:0]      fidx_q, fidx_d;
  logic            lfsr_load, lfsr_step, mismatch;
  logic [15:0]     lfsr_a, lfsr_b;

  // The LFSRs always hold the next random vector; they advance as it is consumed.
  lfsr16 u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (SEED_A),
    .state_o (lfsr_a)
  );

  lfsr16 u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (SEED_B),
    .state_o (lfsr_b)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    a_d       = a_q;
    b_d       = b_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    next_idx  = idx_q + 8'd1;
    mismatch  = (y_in != expected_y(op_q, a_q, b_q));
    err_inc   = (&err_q) ? err_q : err_q + {{(ERRW-1){1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_sel;
          cnt_d     = count;
          idx_d     = 8'd0;
          a_d       = CORNER_A[0];
          b_d       = CORNER_B[0];
          err_d     = '0;
          fidx_d    = 8'hFF;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
          if (count == 8'd0) begin
            state_d = ST_FIN;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        wait_d  = 16'd0;
        state_d = (SETTLE == 1) ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == 16'(WAIT_LAST)) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          // A saturated counter never returns to zero, so this marks the first miss only.
          if (err_q == '0) begin
            fidx_d = idx_q;
          end
        end
        if (next_idx == cnt_q) begin
          state_d = ST_FIN;
          pass_d  = !mismatch && (err_q == '0);
        end else begin
          state_d = ST_DRIVE;
          idx_d   = next_idx;
          if (next_idx[7:2] == 6'd0) begin
            a_d = CORNER_A[next_idx[1:0]];
            b_d = CORNER_B[next_idx[1:0]];
          end else begin
            a_d       = lfsr_a;
            b_d       = lfsr_b;
            lfsr_step = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      wait_q  <= 16'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fidx_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_FIN);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fidx_q;

endmodule
